// File: rtl/rshift_lane_serializer.sv
// Ping-pong capture of full lane vectors from the right-shift bridge,
// replayed one lane per valid/ready transfer toward the score-matmul feeder.
module rshift_lane_serializer #(
  parameter int LANE_WIDTH = 256,
  parameter int NUM_LANES  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] in_data,
  output logic                            in_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [LANE_WIDTH-1:0]           out_data,
  output logic [$clog2(NUM_LANES)-1:0]    out_lane_idx,
  output logic                            out_last,
  output logic                            overflow,
  output logic [CNT_WIDTH-1:0]            vec_count
);

  localparam int IW = $clog2(NUM_LANES);
  localparam int VW = NUM_LANES * LANE_WIDTH;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LANES - 1);

  typedef enum logic {
    IDLE,
    DRAIN
  } rd_state_t;

  rd_state_t      state;
  logic [VW-1:0]  bank [2];
  logic [1:0]     full;
  logic [1:0]     full_nxt;
  logic           wr_sel;
  logic           rd_sel;
  logic           rd_sel_nxt;
  logic [IW-1:0]  lane_cnt;
  logic           cap;
  logic           drop;
  logic           xfer;
  logic           last_lane;
  logic           done;

  assign cap       = in_valid & ~full[wr_sel];
  assign drop      = in_valid & full[wr_sel];
  assign xfer      = out_valid & out_ready;
  assign last_lane = (lane_cnt == LAST_IDX);
  assign done      = xfer & last_lane;

  // A bank freed by the last-lane transfer is only seen empty next cycle,
  // so capture and free never target the same bank on one edge.
  always_comb begin
    full_nxt = full;
    if (cap) begin
      full_nxt[wr_sel] = 1'b1;
    end
    if (done) begin
      full_nxt[rd_sel] = 1'b0;
    end
    rd_sel_nxt = rd_sel ^ done;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      full      <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      lane_cnt  <= '0;
      overflow  <= 1'b0;
      vec_count <= '0;
    end else begin
      full   <= full_nxt;
      rd_sel <= rd_sel_nxt;
      if (cap) begin
        wr_sel    <= ~wr_sel;
        vec_count <= vec_count + CNT_WIDTH'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      if (xfer) begin
        lane_cnt <= last_lane ? '0 : lane_cnt + IW'(1);
      end
      state <= full_nxt[rd_sel_nxt] ? DRAIN : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      bank[wr_sel] <= in_data;
    end
  end

  assign in_ready     = ~(full[0] & full[1]);
  assign out_valid    = (state == DRAIN);
  assign out_lane_idx = lane_cnt;
  assign out_last     = out_valid & last_lane;
  assign out_data     = bank[rd_sel][int'(lane_cnt)*LANE_WIDTH +: LANE_WIDTH];

endmodule

// File: tb/tb_rshift_lane_serializer.sv
// Directed bench for rshift_lane_serializer: capture, drain,
// backpressure, ping-pong, overflow, same-edge free/capture, reset.
module tb_rshift_lane_serializer;

  localparam int LW = 256;
  localparam int NL = 4;
  localparam int CW = 16;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic [NL*LW-1:0] in_data;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [LW-1:0]   out_data;
  logic [1:0]      out_lane_idx;
  logic            out_last;
  logic            overflow;
  logic [CW-1:0]   vec_count;

  int checks;
  int errors;

  rshift_lane_serializer #(
    .LANE_WIDTH(LW),
    .NUM_LANES (NL),
    .CNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_lane_idx(out_lane_idx),
    .out_last    (out_last),
    .overflow    (overflow),
    .vec_count   (vec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NL*LW-1:0] mkvec(input int l0, input int l1,
                                             input int l2, input int l3);
    logic [NL*LW-1:0] v;
    v = '0;
    v[0*LW +: 32] = l0;
    v[1*LW +: 32] = l1;
    v[2*LW +: 32] = l2;
    v[3*LW +: 32] = l3;
    return v;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (out_lane_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_lane_idx: got %0d want 0", out_lane_idx);
    end
    checks++;
    if (out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_last: got %b want 0", out_last);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_overflow: got %b want 0", overflow);
    end
    checks++;
    if (vec_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_vec_count: got %0d want 0", vec_count);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_single();
    int exp_d [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    do_reset();
    out_ready = 1'b1;
    in_data   = mkvec(32'h11, 32'h22, 32'h33, 32'h44);
    in_valid  = 1'b1;
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL single_valid[%0d]: got %b want 1", i, out_valid);
      end
      checks++;
      if (out_data !== LW'(exp_d[i])) begin
        errors++;
        $display("FAIL single_data[%0d]: got %0h want %0h", i, out_data, exp_d[i]);
      end
      checks++;
      if (out_lane_idx !== 2'(i)) begin
        errors++;
        $display("FAIL single_idx[%0d]: got %0d want %0d", i, out_lane_idx, i);
      end
      checks++;
      if (out_last !== (i == 3)) begin
        errors++;
        $display("FAIL single_last[%0d]: got %b want %b", i, out_last, i == 3);
      end
      cycle();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got %b want 0", out_valid);
    end
    checks++;
    if (vec_count !== 16'd1) begin
      errors++;
      $display("FAIL single_vec_count: got %0d want 1", vec_count);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL single_overflow: got %b want 0", overflow);
    end
  endtask

  task automatic test_backpressure();
    logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int   lane [7] = '{0, 1, 1, 1, 2, 3, 3};
    int   exp_d [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    int   xfers;
    do_reset();
    xfers     = 0;
    in_data   = mkvec(32'h11, 32'h22, 32'h33, 32'h44);
    in_valid  = 1'b1;
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i];
      checks++;
      if (out_valid !== 1'b1 || out_lane_idx !== 2'(lane[i])) begin
        errors++;
        $display("FAIL bp_lane[%0d]: got v=%b idx=%0d want v=1 idx=%0d",
                 i, out_valid, out_lane_idx, lane[i]);
      end
      checks++;
      if (out_data !== LW'(exp_d[lane[i]])) begin
        errors++;
        $display("FAIL bp_data[%0d]: got %0h want %0h", i, out_data, exp_d[lane[i]]);
      end
      if (out_valid && out_ready) xfers++;
      cycle();
    end
    out_ready = 1'b0;
    checks++;
    if (xfers !== 4) begin
      errors++;
      $display("FAIL bp_xfers: got %0d want 4", xfers);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle: got %b want 0", out_valid);
    end
  endtask

  task automatic test_ping_pong();
    do_reset();
    out_ready = 1'b1;
    in_data   = mkvec(1, 2, 3, 4);
    in_valid  = 1'b1;
    cycle();
    in_data = mkvec(5, 6, 7, 8);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== LW'(i + 1)) begin
        errors++;
        $display("FAIL pp_data[%0d]: got v=%b d=%0h want v=1 d=%0h",
                 i, out_valid, out_data, i + 1);
      end
      checks++;
      if (in_ready !== !(i >= 1 && i <= 3)) begin
        errors++;
        $display("FAIL pp_in_ready[%0d]: got %b want %b",
                 i, in_ready, !(i >= 1 && i <= 3));
      end
      cycle();
      in_valid = 1'b0;
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pp_idle: got %b want 0", out_valid);
    end
    checks++;
    if (overflow !== 1'b0 || vec_count !== 16'd2) begin
      errors++;
      $display("FAIL pp_status: got ovf=%b cnt=%0d want ovf=0 cnt=2",
               overflow, vec_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = mkvec(1, 2, 3, 4);
    cycle();
    in_data = mkvec(5, 6, 7, 8);
    cycle();
    in_data = mkvec(9, 10, 11, 12);
    cycle();
    in_valid = 1'b0;
    checks++;
    if (overflow !== 1'b1 || vec_count !== 16'd2 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ovf_status: got ovf=%b cnt=%0d rdy=%b want ovf=1 cnt=2 rdy=0",
               overflow, vec_count, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== LW'(i + 1)) begin
        errors++;
        $display("FAIL ovf_data[%0d]: got v=%b d=%0h want v=1 d=%0h",
                 i, out_valid, out_data, i + 1);
      end
      cycle();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_idle: got %b want 0 (dropped vector emitted?)", out_valid);
    end
    checks++;
    if (overflow !== 1'b1 || vec_count !== 16'd2) begin
      errors++;
      $display("FAIL ovf_sticky: got ovf=%b cnt=%0d want ovf=1 cnt=2",
               overflow, vec_count);
    end
  endtask

  task automatic test_same_edge();
    int exp_d [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 32'hD1, 32'hD2, 32'hD3, 32'hD4};
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = mkvec(1, 2, 3, 4);
    cycle();
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== LW'(exp_d[i])) begin
        errors++;
        $display("FAIL se_data[%0d]: got v=%b d=%0h want v=1 d=%0h",
                 i, out_valid, out_data, exp_d[i]);
      end
      if (i == 3 || i == 4) begin
        checks++;
        if (overflow !== (i == 4)) begin
          errors++;
          $display("FAIL se_overflow[%0d]: got %b want %b", i, overflow, i == 4);
        end
      end
      in_valid = 1'b1;
      if (i == 0) in_data = mkvec(5, 6, 7, 8);
      else if (i == 3) in_data = mkvec(9, 10, 11, 12);
      else if (i == 4) in_data = mkvec(32'hD1, 32'hD2, 32'hD3, 32'hD4);
      else in_valid = 1'b0;
      cycle();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b1 || vec_count !== 16'd3) begin
      errors++;
      $display("FAIL se_final: got v=%b ovf=%b cnt=%0d want v=0 ovf=1 cnt=3",
               out_valid, overflow, vec_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = mkvec(1, 2, 3, 4);
    cycle();
    in_data = mkvec(5, 6, 7, 8);
    cycle();
    in_data = mkvec(9, 10, 11, 12);
    cycle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    cycle();
    checks++;
    if (out_lane_idx !== 2'd2 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL rm_pre: got idx=%0d ovf=%b want idx=2 ovf=1",
               out_lane_idx, overflow);
    end
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || vec_count !== 16'd0 ||
        overflow !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rm_post: got v=%b cnt=%0d ovf=%b rdy=%b want v=0 cnt=0 ovf=0 rdy=1",
               out_valid, vec_count, overflow, in_ready);
    end
    in_valid = 1'b1;
    in_data  = mkvec(32'hE1, 32'hE2, 32'hE3, 32'hE4);
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_lane_idx !== 2'(i) ||
          out_data !== LW'(32'hE1 + i)) begin
        errors++;
        $display("FAIL rm_data[%0d]: got v=%b idx=%0d d=%0h want v=1 idx=%0d d=%0h",
                 i, out_valid, out_lane_idx, out_data, i, 32'hE1 + i);
      end
      cycle();
    end
    checks++;
    if (out_valid !== 1'b0 || vec_count !== 16'd1) begin
      errors++;
      $display("FAIL rm_final: got v=%b cnt=%0d want v=0 cnt=1", out_valid, vec_count);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_ping_pong();
    test_overflow();
    test_same_edge();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
